// File: rtl/batch_accum.sv
// Batch accumulator: registers a mode-selected operand, sums ACC_LEN accepted samples
// per batch and publishes the sum with a one-cycle valid pulse and a per-batch overflow flag.
module batch_accum #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ACC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  output logic             ovf
);

  localparam int unsigned     CntW    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACC_LEN - 1);

  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] s1_op_q, s1_op_d;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    op_sel = '0;
    unique case (mode)
      2'd0: op_sel = a | c;
      2'd1: op_sel = ~b;
      2'd2: op_sel = a & b;
      2'd3: op_sel = a ^ c;
      default: op_sel = '0;
    endcase
  end

  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, s1_op_q};
    s1_op_d     = s1_op_q;
    s1_vld_d    = s1_vld_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_acc_d   = ovf_acc_q;
    f_d         = f_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    // A stall (en=0) freezes both stages, so a sample already in stage 1 is kept.
    if (en) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_sel;
      end
      if (s1_vld_q) begin
        if (cnt_q == CntLast) begin
          f_d         = sum[WIDTH-1:0];
          ovf_d       = ovf_acc_q | sum[WIDTH];
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_acc_d   = 1'b0;
        end else begin
          acc_d     = sum[WIDTH-1:0];
          cnt_d     = cnt_q + CntW'(1);
          ovf_acc_d = ovf_acc_q | sum[WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_op_q     <= '0;
      s1_vld_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_acc_q   <= 1'b0;
      f_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_op_q     <= s1_op_d;
      s1_vld_q    <= s1_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_acc_q   <= ovf_acc_d;
      f_q         <= f_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign f         = f_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule
